// File: rtl/accel_host_loader.sv
// Host command front end: streams host words into imem/dmem, starts the core, waits for halt, streams dmem back.
// Latency: load writes in the accept cycle; readback is 2 cycles per byte minimum; in_ready is dropped in RUN/READ states.
module accel_host_loader #(
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 32,
    parameter int DATA_W     = 8,
    parameter int INSTR_W    = 32,
    localparam int IA_W      = $clog2(IMEM_DEPTH),
    localparam int DA_W      = $clog2(DMEM_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               imem_we,
    output logic [IA_W-1:0]    imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               dmem_we,
    output logic               dmem_re,
    output logic [DA_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               core_start,
    input  logic               core_halted,
    output logic               busy,
    output logic               run_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN_PULSE, S_RUN_WAIT, S_READ_REQ, S_READ_OUT
    } state_t;

    typedef enum logic [1:0] {
        CMD_LOAD_I = 2'b00,
        CMD_LOAD_D = 2'b01,
        CMD_RUN    = 2'b10,
        CMD_READ   = 2'b11
    } cmd_t;

    state_t state, state_nxt;
    logic              armed;
    logic [DA_W-1:0]   cur;
    logic [5:0]        rem;
    logic              sel_dmem;
    logic [DATA_W-1:0] hold;
    logic              hold_vld;
    logic              hdr_acc, step;

    cmd_t              hdr_cmd;
    logic [DA_W-1:0]   hdr_base;
    logic [5:0]        hdr_cnt;

    assign hdr_cmd  = cmd_t'(in_data[31:30]);
    assign hdr_base = in_data[16 +: DA_W];
    assign hdr_cnt  = in_data[13:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        dmem_we    = 1'b0;
        dmem_re    = 1'b0;
        core_start = 1'b0;
        run_done   = 1'b0;
        out_valid  = 1'b0;
        hdr_acc    = 1'b0;
        step       = 1'b0;
        case (state)
            S_IDLE: begin
                // armed keeps in_ready low until the first edge after reset release
                in_ready = armed;
                if (in_valid && armed) begin
                    hdr_acc = 1'b1;
                    case (hdr_cmd)
                        CMD_LOAD_I, CMD_LOAD_D: if (hdr_cnt != 6'd0) state_nxt = S_LOAD;
                        CMD_RUN:                state_nxt = S_RUN_PULSE;
                        CMD_READ:               if (hdr_cnt != 6'd0) state_nxt = S_READ_REQ;
                        default:                state_nxt = S_IDLE;
                    endcase
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    step = 1'b1;
                    if (sel_dmem) dmem_we = 1'b1;
                    else          imem_we = 1'b1;
                    if (rem == 6'd1) state_nxt = S_IDLE;
                end
            end
            S_RUN_PULSE: begin
                core_start = 1'b1;
                state_nxt  = S_RUN_WAIT;
            end
            S_RUN_WAIT: begin
                if (core_halted) begin
                    run_done  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_READ_REQ: begin
                dmem_re   = 1'b1;
                state_nxt = S_READ_OUT;
            end
            S_READ_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    step      = 1'b1;
                    state_nxt = (rem == 6'd1) ? S_IDLE : S_READ_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= 1'b0;
            cur      <= '0;
            rem      <= '0;
            sel_dmem <= 1'b0;
            hold     <= '0;
            hold_vld <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (hdr_acc) begin
                cur      <= hdr_base;
                rem      <= hdr_cnt;
                sel_dmem <= (hdr_cmd == CMD_LOAD_D);
            end else if (step) begin
                cur <= cur + 1'b1;
                rem <= rem - 1'b1;
            end
            // First READ_OUT cycle forwards dmem_rdata directly; later cycles replay the captured byte
            if (state == S_READ_REQ) begin
                hold_vld <= 1'b0;
            end else if (state == S_READ_OUT && !hold_vld) begin
                hold     <= dmem_rdata;
                hold_vld <= 1'b1;
            end
        end
    end

    assign imem_addr  = cur[IA_W-1:0];
    assign dmem_addr  = cur;
    assign imem_wdata = imem_we ? in_data : '0;
    assign dmem_wdata = dmem_we ? in_data[DATA_W-1:0] : '0;
    assign out_data   = out_valid ? (hold_vld ? hold : dmem_rdata) : '0;
    assign busy       = (state != S_IDLE);

endmodule
